cp0_exc_arb: RTL and testbench
==============================

CP0_EXC_ARB -- requirements
Module: cp0_exc_arb

Interface
REQ-001 SHALL have parameter EXC_VECTOR, 32'hBFC0_0380, exception handler entry PC.
REQ-002 SHALL have parameter FLUSH_CYCLES, 2, cycles flush is held after a commit (legal 1..7).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports mem_valid in 1 and mem_PC in 32: MEM-stage instruction valid and its PC.
REQ-006 SHALL have port mem_BD  in  1  MEM instruction sits in a branch delay slot.
REQ-007 SHALL have ports exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades  in  1 each  per-instruction exception flags.
REQ-008 SHALL have ports mem_badvaddr in 32 (faulting data address) and mem_eret in 1 (instruction is ERET).
REQ-009 SHALL have ports int_req in 1 (OR of IP&IM, already masked by IE), EXL in 1 (Status.EXL) and cp0_EPC_data in 32.
REQ-010 SHALL have outputs exception 1, exc_code 5, exc_BD 1, exc_PC 32: registered commit record consumed by EPC/Cause/Status.
REQ-011 SHALL have outputs badvaddr_we 1 and exc_badvaddr 32.
REQ-012 SHALL have outputs eret_commit 1, flush 1, redirect_valid 1, redirect_PC 32.

Function
REQ-013 SHALL evaluate an event only when mem_valid=1 and state is IDLE; inputs SHALL be ignored in FLUSH.
REQ-014 SHALL prioritize: Int(0) > AdEL-fetch(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdEL-load(4) > AdES(5); value in parentheses is exc_code.
REQ-015 SHALL treat Int as taken only when int_req=1 and EXL=0.
REQ-016 SHALL register all outputs; exception, exc_code, exc_BD=mem_BD, exc_PC=mem_PC SHALL appear the cycle after the evaluating edge, exception high exactly one cycle.
REQ-017 SHALL pulse badvaddr_we with the exception for AdEL/AdES only; exc_badvaddr SHALL be mem_PC for AdEL-fetch, mem_badvaddr for AdEL-load/AdES.
REQ-018 SHALL still raise exception when EXL=1 (EPC update suppression is the consumer's job); exc_BD, exc_PC SHALL be reported unchanged.
REQ-019 SHALL, on exception, drive redirect_valid=1 and redirect_PC=EXC_VECTOR for one cycle, same cycle as exception.
REQ-020 SHALL, on mem_eret with no exception flag and no taken Int, pulse eret_commit and redirect_valid with redirect_PC=cp0_EPC_data sampled at the evaluating edge.
REQ-021 SHALL give exception precedence over ERET on the same instruction; eret_commit SHALL then stay 0.
REQ-022 SHALL implement FSM IDLE->FLUSH on any commit (exception or ERET); FLUSH holds flush=1 for exactly FLUSH_CYCLES cycles starting with the redirect cycle, via a 3-bit down-counter, then returns to IDLE.
REQ-023 SHALL keep flush, redirect_valid, exception, eret_commit, badvaddr_we at 0 in IDLE with no event; data outputs hold last value.
REQ-024 SHALL not accept a new commit until the counter expires; the IDLE cycle after FLUSH SHALL be evaluable.

Reset
REQ-025 SHALL on rst_n=0 immediately force state=IDLE, counter=0, all 1-bit outputs 0, exc_code=0, exc_PC=exc_badvaddr=redirect_PC=0.
REQ-026 SHALL abort an in-progress FLUSH on reset without further pulses; first evaluation follows the first edge after release.

Configuration
REQ-027 SHALL compile interrupt handling in only when CP0_INT_ARB_EN is defined; without it int_req SHALL be ignored and Int never selected, all other behaviour identical.

Verification
REQ-028 SHALL cover: mem_valid=1, exc_ov=1, mem_PC=32'h8000_0100, BD=0 -> next cycle exception=1, exc_code=12, exc_PC=32'h8000_0100, redirect_PC=32'hBFC0_0380, flush 2 cycles.
REQ-029 SHALL cover: exc_ri=1 and exc_ades=1 together, BD=1 -> exc_code=10, exc_BD=1, badvaddr_we=0.
REQ-030 SHALL cover: exc_ades=1, mem_badvaddr=32'h0000_0003 -> exc_code=5, badvaddr_we=1, exc_badvaddr=32'h0000_0003.
REQ-031 SHALL cover: mem_eret=1, cp0_EPC_data=32'h8000_0200 -> eret_commit=1, redirect_PC=32'h8000_0200, exception=0; repeat with exc_ri=1 -> exception=1, eret_commit=0.
REQ-032 SHALL cover: int_req=1 with EXL=1 then EXL=0 (macro defined) -> no commit, then exc_code=0; macro undefined -> no commit either case.
REQ-033 SHALL cover: rst_n asserted in first FLUSH cycle -> outputs 0 asynchronously; new exc_sys after release commits with exc_code=8.

Source files
------------

// File: rtl/cp0_exc_arb.sv
// ============================================================================
//  Module   : cp0_exc_arb
//  Purpose  : MEM-stage exception/ERET commit arbiter with pipeline flush
//             sequencing. Interrupts compiled in only with CP0_INT_ARB_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_exc_arb #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_PC,
  input  logic        mem_BD,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_adel_ld,
  input  logic        exc_ades,
  input  logic [31:0] mem_badvaddr,
  input  logic        mem_eret,
  input  logic        int_req,
  input  logic        EXL,
  input  logic [31:0] cp0_EPC_data,
  output logic        exception,
  output logic [4:0]  exc_code,
  output logic        exc_BD,
  output logic [31:0] exc_PC,
  output logic        badvaddr_we,
  output logic [31:0] exc_badvaddr,
  output logic        eret_commit,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_PC
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        w_flush_nxt;
  logic        w_eval;
  logic        w_int_taken;
  logic        w_exc_hit;
  logic [4:0]  w_code;
  logic        w_bad_we;
  logic [31:0] w_bad_addr;
  logic        w_eret_hit;
  logic        w_commit;

`ifdef CP0_INT_ARB_EN
  assign w_int_taken = int_req & ~EXL;
`else
  logic w_unused_int;
  assign w_unused_int = int_req ^ EXL;
  assign w_int_taken  = 1'b0;
`endif

  assign w_eval = (r_state == S_IDLE) && mem_valid;

  // Fixed-priority select; later branches only win when all earlier flags are clear
  always_comb begin
    w_exc_hit  = 1'b1;
    w_code     = 5'd0;
    w_bad_we   = 1'b0;
    w_bad_addr = mem_badvaddr;
    if (w_int_taken) begin
      w_code = 5'd0;
    end else if (exc_adel_if) begin
      w_code     = 5'd4;
      w_bad_we   = 1'b1;
      w_bad_addr = mem_PC;
    end else if (exc_ri) begin
      w_code = 5'd10;
    end else if (exc_ov) begin
      w_code = 5'd12;
    end else if (exc_sys) begin
      w_code = 5'd8;
    end else if (exc_bp) begin
      w_code = 5'd9;
    end else if (exc_adel_ld) begin
      w_code   = 5'd4;
      w_bad_we = 1'b1;
    end else if (exc_ades) begin
      w_code   = 5'd5;
      w_bad_we = 1'b1;
    end else begin
      w_exc_hit = 1'b0;
    end
  end

  assign w_eret_hit = mem_eret & ~w_exc_hit;
  assign w_commit   = w_eval & (w_exc_hit | mem_eret);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flush_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = c_FLUSH_LOAD;
          w_flush_nxt = 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
          w_flush_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 3'd0;
      flush          <= 1'b0;
      exception      <= 1'b0;
      eret_commit    <= 1'b0;
      redirect_valid <= 1'b0;
      badvaddr_we    <= 1'b0;
      exc_code       <= 5'd0;
      exc_BD         <= 1'b0;
      exc_PC         <= 32'd0;
      exc_badvaddr   <= 32'd0;
      redirect_PC    <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      flush          <= w_flush_nxt;
      exception      <= w_eval & w_exc_hit;
      eret_commit    <= w_eval & w_eret_hit;
      redirect_valid <= w_commit;
      badvaddr_we    <= w_eval & w_exc_hit & w_bad_we;
      if (w_eval && w_exc_hit) begin
        exc_code <= w_code;
        exc_BD   <= mem_BD;
        exc_PC   <= mem_PC;
      end
      if (w_eval && w_exc_hit && w_bad_we) begin
        exc_badvaddr <= w_bad_addr;
      end
      if (w_commit) begin
        redirect_PC <= w_exc_hit ? EXC_VECTOR : cp0_EPC_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_arb.sv
// ============================================================================
//  Module   : tb_cp0_exc_arb
//  Purpose  : Directed self-checking bench for cp0_exc_arb.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cp0_exc_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_BD, mem_eret, int_req, EXL;
  logic        exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades;
  logic [31:0] mem_PC, mem_badvaddr, cp0_EPC_data;
  logic        exception, exc_BD, badvaddr_we, eret_commit, flush, redirect_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_PC, exc_badvaddr, redirect_PC;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp0_exc_arb #(.EXC_VECTOR(32'hBFC0_0380), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_PC(mem_PC), .mem_BD(mem_BD),
    .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_sys(exc_sys),
    .exc_bp(exc_bp), .exc_adel_ld(exc_adel_ld), .exc_ades(exc_ades),
    .mem_badvaddr(mem_badvaddr), .mem_eret(mem_eret),
    .int_req(int_req), .EXL(EXL), .cp0_EPC_data(cp0_EPC_data),
    .exception(exception), .exc_code(exc_code), .exc_BD(exc_BD), .exc_PC(exc_PC),
    .badvaddr_we(badvaddr_we), .exc_badvaddr(exc_badvaddr),
    .eret_commit(eret_commit), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_PC(redirect_PC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    mem_valid = 0; mem_BD = 0; mem_eret = 0; int_req = 0; EXL = 0;
    exc_adel_if = 0; exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
    exc_adel_ld = 0; exc_ades = 0;
    mem_PC = 32'h0; mem_badvaddr = 32'h0; cp0_EPC_data = 32'h0;
  endtask

  // Clears inputs and lets the flush window run out back to IDLE
  task automatic drain();
    clr_in();
    repeat (3) tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr_in();
    rst_n = 0;
    repeat (2) tick();
    chk("rst_exception", {31'd0, exception}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_PC", redirect_PC, 32'd0);
    chk("rst_exc_code", {27'd0, exc_code}, 32'd0);
    rst_n = 1;
    tick();
    chk("idle_redirect_valid", {31'd0, redirect_valid}, 32'd0);

    // Overflow commit, then an event offered during FLUSH must wait
    mem_valid = 1; exc_ov = 1; mem_PC = 32'h8000_0100;
    tick();
    chk("ov_exception", {31'd0, exception}, 32'd1);
    chk("ov_code", {27'd0, exc_code}, 32'd12);
    chk("ov_PC", exc_PC, 32'h8000_0100);
    chk("ov_BD", {31'd0, exc_BD}, 32'd0);
    chk("ov_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("ov_redirect_PC", redirect_PC, 32'hBFC0_0380);
    chk("ov_flush1", {31'd0, flush}, 32'd1);
    chk("ov_bvwe", {31'd0, badvaddr_we}, 32'd0);
    exc_ov = 0; exc_sys = 1; mem_PC = 32'h8000_0104;
    tick();
    chk("ov_exc_1cyc", {31'd0, exception}, 32'd0);
    chk("ov_redir_1cyc", {31'd0, redirect_valid}, 32'd0);
    chk("ov_flush2", {31'd0, flush}, 32'd1);
    tick();
    chk("ov_flush_end", {31'd0, flush}, 32'd0);
    chk("flush_ignore", {31'd0, exception}, 32'd0);
    tick();
    chk("post_flush_eval", {31'd0, exception}, 32'd1);
    chk("post_flush_code", {27'd0, exc_code}, 32'd8);
    chk("post_flush_PC", exc_PC, 32'h8000_0104);
    drain();

    // RI beats AdES; BD reported
    mem_valid = 1; exc_ri = 1; exc_ades = 1; mem_BD = 1;
    mem_PC = 32'h8000_0040; mem_badvaddr = 32'h0000_1234;
    tick();
    chk("ri_code", {27'd0, exc_code}, 32'd10);
    chk("ri_BD", {31'd0, exc_BD}, 32'd1);
    chk("ri_bvwe", {31'd0, badvaddr_we}, 32'd0);
    chk("ri_badvaddr_hold", exc_badvaddr, 32'd0);
    drain();

    mem_valid = 1; exc_ades = 1; mem_badvaddr = 32'h0000_0003; mem_PC = 32'h8000_0050;
    tick();
    chk("ades_code", {27'd0, exc_code}, 32'd5);
    chk("ades_bvwe", {31'd0, badvaddr_we}, 32'd1);
    chk("ades_badvaddr", exc_badvaddr, 32'h0000_0003);
    tick();
    chk("ades_bvwe_1cyc", {31'd0, badvaddr_we}, 32'd0);
    drain();

    // Fetch AdEL reports the PC, outranking the load AdEL
    mem_valid = 1; exc_adel_if = 1; exc_adel_ld = 1;
    mem_PC = 32'h8000_0007; mem_badvaddr = 32'h0000_0011;
    tick();
    chk("adelif_code", {27'd0, exc_code}, 32'd4);
    chk("adelif_badvaddr", exc_badvaddr, 32'h8000_0007);
    drain();

    mem_valid = 1; exc_adel_ld = 1; mem_badvaddr = 32'h0000_0011; mem_PC = 32'h8000_0060;
    tick();
    chk("adelld_badvaddr", exc_badvaddr, 32'h0000_0011);
    chk("adelld_bvwe", {31'd0, badvaddr_we}, 32'd1);
    drain();

    mem_valid = 1; exc_bp = 1; exc_adel_ld = 1; mem_PC = 32'h8000_0070;
    tick();
    chk("bp_code", {27'd0, exc_code}, 32'd9);
    chk("bp_bvwe", {31'd0, badvaddr_we}, 32'd0);
    drain();

    // ERET commit
    mem_valid = 1; mem_eret = 1; cp0_EPC_data = 32'h8000_0200;
    tick();
    chk("eret_commit", {31'd0, eret_commit}, 32'd1);
    chk("eret_exception", {31'd0, exception}, 32'd0);
    chk("eret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("eret_redirect_PC", redirect_PC, 32'h8000_0200);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_code_hold", {27'd0, exc_code}, 32'd9);
    drain();

    mem_valid = 1; mem_eret = 1; exc_ri = 1; cp0_EPC_data = 32'h8000_0200;
    mem_PC = 32'h8000_0080;
    tick();
    chk("eret_ri_exception", {31'd0, exception}, 32'd1);
    chk("eret_ri_commit", {31'd0, eret_commit}, 32'd0);
    chk("eret_ri_redirect_PC", redirect_PC, 32'hBFC0_0380);
    drain();

    // Interrupt gating by EXL and by the build option
    mem_valid = 1; int_req = 1; EXL = 1; mem_PC = 32'h8000_0090;
    tick();
    chk("int_exl_exception", {31'd0, exception}, 32'd0);
    chk("int_exl_flush", {31'd0, flush}, 32'd0);
    EXL = 0;
    tick();
`ifdef CP0_INT_ARB_EN
    chk("int_exception", {31'd0, exception}, 32'd1);
    chk("int_code", {27'd0, exc_code}, 32'd0);
`else
    chk("int_off_exception", {31'd0, exception}, 32'd0);
    chk("int_off_redirect", {31'd0, redirect_valid}, 32'd0);
`endif
    drain();

    // EXL set: exception still raised with PC/BD unchanged
    mem_valid = 1; exc_ov = 1; EXL = 1; mem_BD = 1; mem_PC = 32'h8000_00A0;
    tick();
    chk("exl_exception", {31'd0, exception}, 32'd1);
    chk("exl_PC", exc_PC, 32'h8000_00A0);
    chk("exl_BD", {31'd0, exc_BD}, 32'd1);
    drain();

    // Reset in first FLUSH cycle
    mem_valid = 1; exc_ov = 1; mem_PC = 32'h8000_00B0;
    tick();
    clr_in();
    #2 rst_n = 0;
    #1;
    chk("arst_flush", {31'd0, flush}, 32'd0);
    chk("arst_exception", {31'd0, exception}, 32'd0);
    chk("arst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("arst_redirect_PC", redirect_PC, 32'd0);
    chk("arst_exc_PC", exc_PC, 32'd0);
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_flush", {31'd0, flush}, 32'd0);
    mem_valid = 1; exc_sys = 1; mem_PC = 32'h8000_00C0;
    tick();
    chk("post_rst_exception", {31'd0, exception}, 32'd1);
    chk("post_rst_code", {27'd0, exc_code}, 32'd8);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
